reaction_arena: RTL and testbench
=================================

Name: reaction_arena

Overview:
- Multi-player, multi-round reaction-time game controller. Successor to the single-player reaction FSM/timer pair.
- Inputs: a start pulse, one debounced press pulse per player, and a random delay from the rng block.
- Times the random wait, lights the stimulus LED, then records each player's reaction time in milliseconds.
- Also provides false-start detection, winner arbitration, timeout handling and a best-time register. Outputs feed the display and LED logic at top level.

Parameters:
- N_PLAYERS, 2, number of player button channels (1..8).
- MAX_MS, 2047, reaction-time saturation/timeout value in ms.
- CLKS_PER_MS, 50000, clk cycles per ms tick (50 MHz clock).
- MIN_DELAY_MS, 500, minimum wait before the stimulus; smaller random delays are clamped up to this.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: begin a round
- btn_pressed  in  N_PLAYERS  single-cycle debounced press pulse per player
- random_value  in  TW  random delay in ms; TW = $clog2(MAX_MS+1)
- led_on  out  1  stimulus LED; high only in REACT
- busy  out  1  high in WAIT or REACT
- round_done  out  1  one-cycle pulse on entry to RESULT
- player_time  out  N_PLAYERS*TW  per-player reaction time in ms; player i occupies bits [i*TW +: TW]
- false_start  out  N_PLAYERS  player pressed during WAIT this round
- winner  out  WW  index of the round winner; WW = max(1, $clog2(N_PLAYERS))
- winner_valid  out  1  a winner exists for this round
- best_time  out  TW  lowest winning time since reset

Behaviour:
- Reset (synchronous): state=IDLE.
  - led_on=0, busy=0, round_done=0, winner_valid=0, winner=0.
  - player_time all = MAX_MS; false_start=0; best_time=MAX_MS.
  - Prescaler and ms counter cleared.
  - Reset asserted mid-round aborts the round with no round_done pulse.
- ms tick: internal prescaler counts 0..CLKS_PER_MS-1 and pulses tick on the wrap. It restarts at 0 on every state entry, so the first tick comes exactly CLKS_PER_MS cycles after entry.
- IDLE / RESULT, start=1 → WAIT, next cycle.
  - Latch delay = max(random_value, MIN_DELAY_MS).
  - Clear false_start, winner_valid, winner; set player_time all = MAX_MS. best_time is retained.
  - In RESULT, all outputs hold until start.
- WAIT:
  - Ms counter counts up on each tick; at count == delay → REACT, with the counter reset to 0.
  - btn_pressed[i] in WAIT sets false_start[i]; that player is locked out for the rest of the round.
  - If every player has false-started → RESULT (winner_valid=0).
  - start is ignored while in WAIT.
- REACT:
  - led_on=1; ms counter increments on each tick, saturating at MAX_MS.
  - The first btn_pressed[i] from a non-locked player records player_time[i] = current count. Later presses from that player are ignored.
  - First recorder becomes the winner: winner_valid=1.
  - Simultaneous first presses in the same cycle: lowest index wins; all of them record the same time.
  - → RESULT when every non-false-started player has recorded a time, or when the count reaches MAX_MS (timeout).
  - On timeout, unrecorded players keep MAX_MS; winner_valid stays 0 if nobody pressed.
  - start is ignored while in REACT.
- Entering RESULT:
  - round_done pulses for 1 cycle; led_on=0.
  - If winner_valid and player_time[winner] < best_time, best_time updates on the same cycle as the round_done pulse.
- A press and a state-exit condition in the same cycle: the press is recorded first, using the pre-transition state.
- Outputs are registered. Latency from a press pulse to player_time/winner visibility is 1 cycle.

Test Plan (sim uses CLKS_PER_MS=4, N_PLAYERS=2, MIN_DELAY_MS=5, MAX_MS=2047):
- Normal round: random_value=10, start. P1 presses 23 ticks after LED on, P0 at 30 → player_time={30,23}, winner=1, winner_valid=1, best_time=23, one round_done pulse.
- Clamp and false start: random_value=2. → LED rises after 5 ms. P0 presses during WAIT → false_start=01. P1 presses at 7 → winner=1, player_time[0]=2047, round ends on P1's press.
- Tie: both players press in the same cycle at 12 → winner=0, both times 12; best_time updated only if 12 < previous.
- Timeout: no presses in REACT → RESULT after 2047 ms, all times 2047, winner_valid=0, best_time unchanged.
- All false start: both players press in WAIT → immediate RESULT, led_on never rises, winner_valid=0.
- Reset mid-REACT: assert reset → next cycle IDLE, led_on=0, best_time=2047, no round_done. start during WAIT/REACT is ignored, and the round still completes normally.

Source files
------------

// File: rtl/reaction_arena.sv
`timescale 1ns/1ps
// Multi-player reaction-time game: random wait, stimulus LED, per-player ms timing, winner and best time.
// Outputs are registered, so a press shows up one cycle later. Pulse inputs only, no backpressure.
module reaction_arena #(
  parameter int N_PLAYERS    = 2,
  parameter int MAX_MS       = 2047,
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 500,
  localparam int TW = $clog2(MAX_MS + 1),
  localparam int WW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_PLAYERS-1:0]    btn_pressed,
  input  logic [TW-1:0]           random_value,
  output logic                    led_on,
  output logic                    busy,
  output logic                    round_done,
  output logic [N_PLAYERS*TW-1:0] player_time,
  output logic [N_PLAYERS-1:0]    false_start,
  output logic [WW-1:0]           winner,
  output logic                    winner_valid,
  output logic [TW-1:0]           best_time
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [TW-1:0] MAX_T    = TW'(MAX_MS);
  localparam logic [TW-1:0] MIN_T    = TW'(MIN_DELAY_MS);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REACT, RESULT} state_t;

  state_t                  state, nxt_state;
  logic [PW-1:0]           presc;
  logic [TW-1:0]           ms_cnt;
  logic [TW-1:0]           delay, nxt_delay;
  logic [N_PLAYERS-1:0]    recorded, nxt_rec, nxt_fs, new_press;
  logic [N_PLAYERS*TW-1:0] nxt_pt;
  logic                    nxt_wv;
  logic [WW-1:0]           nxt_win;
  logic [TW-1:0]           win_time;
  logic                    tick;
  logic                    entering;
  logic                    wait_done;

  assign tick      = (presc == PRE_LAST);
  assign entering  = (nxt_state != state);
  assign wait_done = tick && (({1'b0, ms_cnt} + 1'b1) >= {1'b0, delay});

  always_comb begin
    nxt_state = state;
    nxt_delay = delay;
    nxt_rec   = recorded;
    nxt_fs    = false_start;
    nxt_pt    = player_time;
    nxt_wv    = winner_valid;
    nxt_win   = winner;
    new_press = '0;
    win_time  = MAX_T;
    case (state)
      IDLE, RESULT: begin
        if (start) begin
          nxt_state = WAIT;
          nxt_delay = (random_value < MIN_T) ? MIN_T : random_value;
          nxt_rec   = '0;
          nxt_fs    = '0;
          nxt_pt    = {N_PLAYERS{MAX_T}};
          nxt_wv    = 1'b0;
          nxt_win   = '0;
        end
      end
      WAIT: begin
        nxt_fs = false_start | btn_pressed;
        if (&nxt_fs) begin
          nxt_state = RESULT;
        end else if (wait_done) begin
          nxt_state = REACT;
        end
      end
      REACT: begin
        new_press = btn_pressed & ~(false_start | recorded);
        nxt_rec   = recorded | new_press;
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (new_press[i]) nxt_pt[i*TW +: TW] = ms_cnt;
        end
        // Descending scan leaves the lowest simultaneous presser as winner.
        if (!winner_valid && (|new_press)) begin
          nxt_wv = 1'b1;
          for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (new_press[i]) nxt_win = WW'(i);
          end
        end
        if (((nxt_rec | false_start) == {N_PLAYERS{1'b1}}) || (ms_cnt == MAX_T)) begin
          nxt_state = RESULT;
        end
      end
      default: nxt_state = IDLE;
    endcase
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (nxt_win == WW'(i)) win_time = nxt_pt[i*TW +: TW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      ms_cnt       <= '0;
      delay        <= MIN_T;
      recorded     <= '0;
      false_start  <= '0;
      player_time  <= {N_PLAYERS{MAX_T}};
      winner       <= '0;
      winner_valid <= 1'b0;
      best_time    <= MAX_T;
      led_on       <= 1'b0;
      busy         <= 1'b0;
      round_done   <= 1'b0;
    end else begin
      state        <= nxt_state;
      delay        <= nxt_delay;
      recorded     <= nxt_rec;
      false_start  <= nxt_fs;
      player_time  <= nxt_pt;
      winner       <= nxt_win;
      winner_valid <= nxt_wv;
      led_on       <= (nxt_state == REACT);
      busy         <= (nxt_state == WAIT) || (nxt_state == REACT);
      round_done   <= entering && (nxt_state == RESULT);
      if (entering && (nxt_state == RESULT) && nxt_wv && (win_time < best_time)) begin
        best_time <= win_time;
      end
      // Timebase restarts on every state entry so the first tick is a full ms later.
      if (entering) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && ((state == WAIT) || ((state == REACT) && (ms_cnt != MAX_T)))) begin
          ms_cnt <= ms_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reaction_arena.sv
`timescale 1ns/1ps
// Bench for reaction_arena: scripted rounds with fixed expectations plus random rounds against a ms-level model.
module tb_reaction_arena;

  localparam int N    = 2;
  localparam int MAX  = 2047;
  localparam int C    = 4;
  localparam int MIND = 5;
  localparam int TW   = 11;
  localparam int WW   = 1;
  localparam int LIMIT = 12000;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [N-1:0]    btn;
  logic [TW-1:0]   rv;
  logic            led_on, busy, round_done, winner_valid;
  logic [N*TW-1:0] player_time;
  logic [N-1:0]    false_start;
  logic [WW-1:0]   winner;
  logic [TW-1:0]   best_time;

  always #5 clk = ~clk;

  reaction_arena #(
    .N_PLAYERS(N), .MAX_MS(MAX), .CLKS_PER_MS(C), .MIN_DELAY_MS(MIND)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_pressed(btn), .random_value(rv),
    .led_on(led_on), .busy(busy), .round_done(round_done), .player_time(player_time),
    .false_start(false_start), .winner(winner), .winner_valid(winner_valid), .best_time(best_time)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks phase and cycles elapsed; reaction count is elapsed cycles / C.
  localparam int M_IDLE = 0, M_WAIT = 1, M_REACT = 2, M_RES = 3;
  int       m_state, m_n, m_delay, m_cnt, m_best, m_win;
  int       m_t[N];
  bit [N-1:0] m_fs, m_rec;
  bit       m_wv, m_rd;

  task automatic enter_result();
    m_state = M_RES;
    m_rd    = 1'b1;
    if (m_wv && (m_t[m_win] < m_best)) m_best = m_t[m_win];
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_state = M_IDLE; m_n = 0; m_fs = '0; m_rec = '0; m_wv = 1'b0; m_win = 0;
      m_rd = 1'b0; m_best = MAX; m_delay = MIND;
      for (int i = 0; i < N; i++) m_t[i] = MAX;
    end else begin
      m_rd = 1'b0;
      case (m_state)
        M_IDLE, M_RES: if (start) begin
          m_state = M_WAIT; m_n = 0;
          m_delay = (int'(rv) < MIND) ? MIND : int'(rv);
          m_fs = '0; m_rec = '0; m_wv = 1'b0; m_win = 0;
          for (int i = 0; i < N; i++) m_t[i] = MAX;
        end
        M_WAIT: begin
          m_n++;
          m_fs = m_fs | btn;
          if (m_fs == {N{1'b1}}) enter_result();
          else if (m_n == m_delay * C) begin m_state = M_REACT; m_n = 0; end
        end
        M_REACT: begin
          m_n++;
          m_cnt = (m_n - 1) / C;
          if (m_cnt > MAX) m_cnt = MAX;
          for (int i = 0; i < N; i++) begin
            if (btn[i] && !m_fs[i] && !m_rec[i]) begin
              m_t[i] = m_cnt; m_rec[i] = 1'b1;
              if (!m_wv) begin m_wv = 1'b1; m_win = i; end
            end
          end
          if (((m_rec | m_fs) == {N{1'b1}}) || (m_cnt == MAX)) enter_result();
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  logic [N*TW-1:0] e_pt;
  logic [3*TW+6:0] act_v, exp_v;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) e_pt[i*TW +: TW] = TW'(m_t[i]);
      act_v = {led_on, busy, round_done, player_time, false_start, winner, winner_valid, best_time};
      exp_v = {(m_state == M_REACT), (m_state == M_WAIT || m_state == M_REACT), m_rd, e_pt,
               m_fs, WW'(m_win), m_wv, TW'(m_best)};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t: dut=%h model=%h", $time, act_v, exp_v);
      end
    end
  end

  typedef struct {
    int rv; int w0; int w1; int p0; int p1; int xs;
    int e_t0; int e_t1; int e_fs; int e_win; int e_wv; int e_best; int e_led;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input int idx, input vec_t v);
    int k, led_at, done_cnt;
    bit done;
    rv = TW'(v.rv); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; led_at = -1; done_cnt = 0; done = 1'b0;
    while (!done && k < LIMIT) begin
      if (led_on && led_at < 0) led_at = k;
      if (round_done) begin done_cnt++; done = 1'b1; end
      btn = '0; start = 1'b0;
      if (!done) begin
        if (v.w0 != 0 && k == 1) btn[0] = 1'b1;
        if (v.w1 != 0 && k == 1) btn[1] = 1'b1;
        if (led_at >= 0 && v.p0 >= 0 && k == led_at + v.p0 * C + 1) btn[0] = 1'b1;
        if (led_at >= 0 && v.p1 >= 0 && k == led_at + v.p1 * C + 1) btn[1] = 1'b1;
        if (v.xs != 0 && (k == 3 || (led_at >= 0 && k == led_at + 5))) start = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    btn = '0; start = 1'b0;
    if (!done) check($sformatf("v%0d_round_timeout", idx), 0, 1);
    repeat (3) begin
      @(negedge clk);
      if (round_done) done_cnt++;
    end
    check($sformatf("v%0d_round_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_led_rise_cycle", idx), led_at, v.e_led);
    check($sformatf("v%0d_time0", idx), int'(player_time[0 +: TW]), v.e_t0);
    check($sformatf("v%0d_time1", idx), int'(player_time[TW +: TW]), v.e_t1);
    check($sformatf("v%0d_false_start", idx), int'(false_start), v.e_fs);
    check($sformatf("v%0d_winner_valid", idx), int'(winner_valid), v.e_wv);
    check($sformatf("v%0d_winner", idx), int'(winner), v.e_win);
    check($sformatf("v%0d_best", idx), int'(best_time), v.e_best);
  endtask

  initial begin
    int k, dc;
    //           rv w0 w1  p0  p1 xs   t0    t1  fs win wv best led
    vt[0] = '{10, 0, 0,  30,  23, 0,   30,   23, 0, 1, 1, 23, 40};
    vt[1] = '{ 2, 1, 0,  -1,   7, 0, 2047,    7, 1, 1, 1,  7, 20};
    vt[2] = '{ 8, 0, 0,  12,  12, 0,   12,   12, 0, 0, 1,  7, 32};
    vt[3] = '{ 5, 0, 0,  -1,  -1, 0, 2047, 2047, 0, 0, 0,  7, 20};
    vt[4] = '{ 9, 1, 1,  -1,  -1, 0, 2047, 2047, 3, 0, 0,  7, -1};
    vt[5] = '{ 0, 0, 0,   3,   3, 0,    3,    3, 0, 0, 1,  3, 20};
    vt[6] = '{ 6, 0, 0,   4,   9, 1,    4,    9, 0, 0, 1,  4, 24};

    reset = 1'b1; start = 1'b0; btn = '0; rv = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_led_on", int'(led_on), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_round_done", int'(round_done), 0);
    check("rst_winner_valid", int'(winner_valid), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_false_start", int'(false_start), 0);
    check("rst_time0", int'(player_time[0 +: TW]), MAX);
    check("rst_time1", int'(player_time[TW +: TW]), MAX);
    check("rst_best", int'(best_time), MAX);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

    // Reset in the middle of REACT aborts the round silently.
    rv = TW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!led_on && k < 200) begin @(negedge clk); k++; end
    check("midrst_led_seen", int'(led_on), 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_led_off", int'(led_on), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_best", int'(best_time), MAX);
    check("midrst_time0", int'(player_time[0 +: TW]), MAX);
    reset = 1'b0;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (round_done) dc++;
    end
    check("midrst_no_round_done", dc, 0);

    run_vec(6, vt[6]);

    // Random rounds, checked cycle by cycle against the model.
    for (int r = 0; r < 25; r++) begin
      rv = TW'($urandom_range(0, 14));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!round_done && k < LIMIT) begin
        for (int i = 0; i < N; i++) btn[i] = ($urandom_range(0, 99) < 2);
        start = ($urandom_range(0, 99) == 0);
        @(negedge clk);
        k++;
      end
      btn = '0; start = 1'b0;
      if (k >= LIMIT) check($sformatf("rand%0d_round_timeout", r), 0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
